// File: rtl/decode_pkg.sv
// Shared RV32I decode types: opcode constants, operation enum and the decoded record.
// The M-extension operations are always enumerated; whether they decode depends on RV32M_EN.
package decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // OP_ILLEGAL is zero so an all-zero entry reads back as an illegal-op record.
    typedef enum logic [5:0] {
        OP_ILLEGAL,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_t;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

    typedef struct packed {
        logic [31:0] pc;
        op_t         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } decoded_t;

    function automatic logic [31:0] imm_of(input fmt_t fmt, input logic [31:0] i);
        case (fmt)
            FMT_I:   return {{20{i[31]}}, i[31:20]};
            FMT_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_U:   return {i[31:12], 12'b0};
            FMT_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and consumer-side handshake bundle of the decode queue.
interface decode_queue_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
);
    import decode_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    decoded_t         out_dec;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_dec, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_dec, count
    );

endinterface

// File: rtl/decode_comb.sv
// Combinational RV32I decoder producing one decoded_t record per instruction word.
// Define RV32M_EN to decode the M-extension (funct7 = 0000001) OP encodings.
module decode_comb
    import decode_pkg::*;
(
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output decoded_t    dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    op_t        op;
    fmt_t       fmt;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        op  = OP_ILLEGAL;
        fmt = FMT_R;
        case (opcode)
            OPC_LUI:   begin op = OP_LUI;   fmt = FMT_U; end
            OPC_AUIPC: begin op = OP_AUIPC; fmt = FMT_U; end
            OPC_JAL:   begin op = OP_JAL;   fmt = FMT_J; end
            OPC_JALR: begin
                fmt = FMT_I;
                if (funct3 == 3'b000) op = OP_JALR;
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                case (funct3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                fmt = FMT_I;
                case (funct3)
                    3'b000:  op = OP_LB;
                    3'b001:  op = OP_LH;
                    3'b010:  op = OP_LW;
                    3'b100:  op = OP_LBU;
                    3'b101:  op = OP_LHU;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                fmt = FMT_S;
                case (funct3)
                    3'b000:  op = OP_SB;
                    3'b001:  op = OP_SH;
                    3'b010:  op = OP_SW;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_OP_IMM: begin
                fmt = FMT_I;
                case (funct3)
                    3'b000: op = OP_ADDI;
                    3'b010: op = OP_SLTI;
                    3'b011: op = OP_SLTIU;
                    3'b100: op = OP_XORI;
                    3'b110: op = OP_ORI;
                    3'b111: op = OP_ANDI;
                    3'b001: if (funct7 == F7_BASE) op = OP_SLLI;
                    default: begin
                        if (funct7 == F7_BASE)     op = OP_SRLI;
                        else if (funct7 == F7_ALT) op = OP_SRAI;
                    end
                endcase
            end
            OPC_OP: begin
                fmt = FMT_R;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}:   op = OP_ADD;
                    {F7_ALT,  3'b000}:   op = OP_SUB;
                    {F7_BASE, 3'b001}:   op = OP_SLL;
                    {F7_BASE, 3'b010}:   op = OP_SLT;
                    {F7_BASE, 3'b011}:   op = OP_SLTU;
                    {F7_BASE, 3'b100}:   op = OP_XOR;
                    {F7_BASE, 3'b101}:   op = OP_SRL;
                    {F7_ALT,  3'b101}:   op = OP_SRA;
                    {F7_BASE, 3'b110}:   op = OP_OR;
                    {F7_BASE, 3'b111}:   op = OP_AND;
`ifdef RV32M_EN
                    {F7_MULDIV, 3'b000}: op = OP_MUL;
                    {F7_MULDIV, 3'b001}: op = OP_MULH;
                    {F7_MULDIV, 3'b010}: op = OP_MULHSU;
                    {F7_MULDIV, 3'b011}: op = OP_MULHU;
                    {F7_MULDIV, 3'b100}: op = OP_DIV;
                    {F7_MULDIV, 3'b101}: op = OP_DIVU;
                    {F7_MULDIV, 3'b110}: op = OP_REM;
                    {F7_MULDIV, 3'b111}: op = OP_REMU;
`else
                    // M encodings fall through to illegal when the extension is absent.
`endif
                    default:             op = OP_ILLEGAL;
                endcase
            end
            OPC_MISC_MEM: begin
                fmt = FMT_I;
                if (funct3 == 3'b000) op = OP_FENCE;
            end
            OPC_SYSTEM: begin
                fmt = FMT_I;
                if (in_instr[31:7] == 25'h0000000)      op = OP_ECALL;
                else if (in_instr[31:7] == 25'h0002000) op = OP_EBREAK;
            end
            default: op = OP_ILLEGAL;
        endcase
    end

    // Illegal words keep their pc but carry no register indices or immediate.
    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.op      = op;
        dec.illegal = (op == OP_ILLEGAL);
        if (op != OP_ILLEGAL) begin
            if (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) dec.rs1 = in_instr[19:15];
            if (fmt inside {FMT_R, FMT_S, FMT_B})        dec.rs2 = in_instr[24:20];
            if (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) dec.rd  = in_instr[11:7];
            dec.imm = imm_of(fmt, in_instr);
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Registered RV32I decode stage: decoder in front of a DEPTH-entry FIFO of decoded records.
// RV32M_EN (see decode_comb) enables decoding of the M-extension operations.
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input logic           clk,
    input logic           rstn,
    decode_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);

    decoded_t         in_dec;
    decoded_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             out_valid;
    logic             in_ready;
    logic             push;
    logic             pop;

    decode_comb u_decode_comb (
        .in_instr (bus.in_instr),
        .in_pc    (bus.in_pc),
        .dec      (in_dec)
    );

    // A full queue still accepts when the head leaves in the same cycle.
    assign out_valid = (count != '0);
    assign in_ready  = (count != CNT_W'(DEPTH)) || (bus.out_ready && out_valid);
    assign push      = bus.in_valid && in_ready && !bus.flush;
    assign pop       = out_valid && bus.out_ready && !bus.flush;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.count     = count;
    assign bus.out_dec   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the entry array is reset so the head reads a defined all-zero record out of reset; flush leaves it alone.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= in_dec;
        end
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Registered, parametrised RV32I decode stage that sits between fetch and register-read/execute. It accepts raw instruction words and their PCs over a valid/ready handshake. Each word is fully decoded into a packed `decoded_t` record: operation, register indices, sign-extended immediate and illegal flag. Records are buffered in a DEPTH-entry FIFO so fetch can run ahead of a stalled back end, and a single-cycle flush discards all buffered work on redirect.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.
- `CNT_W`, default `$clog2(DEPTH)+1`: width of the occupancy count; derived, not overridden.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rstn`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: fetch presents a word.
- `in_ready`  out  1: the queue can accept this cycle.
- `in_pc`  in  32: PC of the word.
- `in_instr`  in  32: raw instruction.
- `flush`  in  1: discard all entries and any word presented this cycle.
- `out_valid`  out  1: the head entry is valid.
- `out_ready`  in  1: the consumer takes the head.
- `out_dec`  out  `decoded_t`: head record (pc, op, rd, rs1, rs2, imm, illegal).
- `count`  out  `CNT_W`: current occupancy.

## Operation
- Decode is combinational on `in_instr`; the result is written into the FIFO when `in_valid && in_ready && !flush` (a push).
- Register indices:
  - `rs1` = instr[19:15] for R/I/S/B formats, else 0.
  - `rs2` = instr[24:20] for R/S/B formats, else 0.
  - `rd` = instr[11:7] for R/I/U/J formats, else 0.
- Immediates are sign-extended to 32 bits per format:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R format: 0.
- `op` enumerates every RV32I instruction: LUI, AUIPC, JAL, JALR, the 6 branches, 5 loads, 3 stores, 9 OP-IMM, 10 OP, FENCE, ECALL, EBREAK.
- `illegal` is set on an unknown opcode, an unknown funct3/funct7 combination, or an all-zero word. An illegal word is still queued, with `op` = OP_ILLEGAL and `rd`/`rs1`/`rs2`/`imm` = 0.
- Pop happens when `out_valid && out_ready && !flush`.
- FIFO pointers are `$clog2(DEPTH)` bits wide and wrap naturally. `count` is updated by +1 on push, -1 on pop, and is unchanged on simultaneous push and pop.
- `in_ready` = (count != DEPTH) || (out_ready && out_valid). A push into a full queue is therefore allowed in the same cycle as a pop.
- `out_valid` = (count != 0). `out_dec` is driven from the head entry register; there is no combinational path from `in_*` to `out_*`.
- Flush has priority over push and pop. On the next edge count = 0 and both pointers = 0. The entry RAM is not cleared.

## Timing
- Reset values: count = 0, both pointers = 0, out_valid = 0, in_ready = 1. `out_dec` reads entry 0, which is reset to all-zero (op = OP_ILLEGAL, illegal = 0).
- Latency: a word accepted at edge N into an empty queue has out_valid = 1 in cycle N+1.
- Throughput: one push and one pop per cycle sustained, for any DEPTH.
- Full queue with out_ready = 0: in_ready = 0 and `in_*` is ignored.
- Empty queue with out_ready = 1: no pop, and count never underflows.
- Reset asserted mid-operation: all state returns immediately to the reset values, independent of `clk`.

## Configuration
- `RV32M_EN` defined:
  - OP with funct7 = 0000001 decodes to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - These are R-format with illegal = 0.
- `RV32M_EN` undefined:
  - Those encodings decode as illegal = 1, op = OP_ILLEGAL.
  - The enum members for the M operations remain present so `decoded_t` width is unchanged.

## Structure
- Package `decode_pkg` holds:
  - opcode localparams (OPC_LUI = 7'b0110111, etc.);
  - `op_t` enum;
  - `decoded_t` packed struct (pc 32, op, rd 5, rs1 5, rs2 5, imm 32, illegal 1).
- Sub-module `decode_comb`: purely combinational, `in_instr` and `in_pc` in, `decoded_t` out. It is instantiated once, in front of the FIFO.
- `decode_queue` holds only the FIFO, pointers, count and handshake logic.

## Test plan
- Push 0x00510093 (addi x1,x2,5) at pc 0x100 into an empty queue. Next cycle: out_valid = 1, op = ADDI, rd = 1, rs1 = 2, rs2 = 0, imm = 5, pc = 0x100, count = 1.
- Push 0x123452B7 (lui x5,0x12345), then 0xFE208EE3 (beq x1,x2,-4):
  - LUI gives imm = 0x12345000, rd = 5, rs1 = rs2 = 0.
  - BEQ gives imm = 0xFFFFFFFC, rs1 = 1, rs2 = 2, rd = 0.
- Hold out_ready = 0 and push DEPTH+1 words. in_ready must drop after the DEPTH-th push and count must equal DEPTH. Then raise out_ready: the words drain in order, and on the full-cycle a simultaneous push and pop keeps count = DEPTH.
- With 3 entries queued, assert flush together with in_valid = 1. Next cycle: count = 0, out_valid = 0, and the flushed-cycle word never appears at the output.
- Push 0x022081B3 (mul x3,x1,x2):
  - With `RV32M_EN`: op = MUL, rd = 3, illegal = 0.
  - Without it: illegal = 1, op = OP_ILLEGAL.
- Push 0x00000000 and 0xFFFFFFFF: both emerge with illegal = 1. Then assert rstn low with entries queued: count = 0 and out_valid = 0 without waiting for a clock edge.
